// File: rtl/rs_br_slot_pkg.sv
// rs_br_slot_pkg: shared widths, slot state encoding and CDB lane record for
// the branch reservation-station slot and its operand snoop sub-module.
package rs_br_slot_pkg;

  localparam int XLEN    = 32;
  localparam int TAG_W   = 5;
  localparam int NUM_CDB = 2;

  typedef enum logic [2:0] {
    SLOT_EMPTY    = 3'd0,
    SLOT_WAIT_OPS = 3'd1,
    SLOT_ISSUE    = 3'd2,
    SLOT_EXEC     = 3'd3,
    SLOT_DONE     = 3'd4
  } slot_state_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } cdb_lane_t;

endpackage

// File: rtl/rs_operand_snoop.sv
// rs_operand_snoop: one source operand of the slot. Holds producer tag, value
// and ready flag, and compares the tag against every CDB lane.
// Ports:
//   clock, reset       clock / async active-low reset
//   clear              drop the operand (squash or completion)
//   load               dispatch accepted this cycle
//   snoop              slot is waiting for operands
//   disp_tag/ready/value  dispatched operand fields
//   cdb                unpacked CDB lanes (lane 0 has priority)
//   ready_nxt          next-cycle ready flag (used by the slot FSM)
//   ready, value       registered operand state
module rs_operand_snoop
  import rs_br_slot_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             snoop,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic             disp_ready,
  input  logic [XLEN-1:0]  disp_value,
  input  cdb_lane_t        cdb [NUM_CDB],
  output logic             ready_nxt,
  output logic             ready,
  output logic [XLEN-1:0]  value
);

  logic [TAG_W-1:0] tag_r;
  logic             ready_r;
  logic [XLEN-1:0]  value_r;
  logic [TAG_W-1:0] cmp_tag_s;
  logic [TAG_W-1:0] tag_nxt_s;
  logic [XLEN-1:0]  value_nxt_s;
  logic             hit_s;
  logic [XLEN-1:0]  hit_value_s;

  // CDB match; scanning from the top lane down lets lane 0 win on multiple hits.
  // In the dispatch cycle the incoming tag is compared so a same-cycle broadcast is forwarded.
  always_comb begin
    cmp_tag_s   = load ? disp_tag : tag_r;
    hit_s       = 1'b0;
    hit_value_s = {XLEN{1'b0}};
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb[i].valid && (cdb[i].tag == cmp_tag_s)) begin
        hit_s       = 1'b1;
        hit_value_s = cdb[i].value;
      end else begin
        hit_s       = hit_s;
        hit_value_s = hit_value_s;
      end
    end
  end

  // Next operand state: clear beats load beats wakeup; a ready operand ignores the CDB.
  always_comb begin
    ready_nxt   = ready_r;
    value_nxt_s = value_r;
    tag_nxt_s   = tag_r;
    if (clear) begin
      ready_nxt   = 1'b0;
      value_nxt_s = {XLEN{1'b0}};
      tag_nxt_s   = {TAG_W{1'b0}};
    end else if (load) begin
      tag_nxt_s   = disp_tag;
      ready_nxt   = disp_ready | hit_s;
      value_nxt_s = disp_ready ? disp_value : (hit_s ? hit_value_s : {XLEN{1'b0}});
    end else if (snoop && !ready_r && hit_s) begin
      ready_nxt   = 1'b1;
      value_nxt_s = hit_value_s;
    end else begin
      ready_nxt   = ready_r;
      value_nxt_s = value_r;
    end
  end

  // Operand state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_r   <= {TAG_W{1'b0}};
      ready_r <= 1'b0;
      value_r <= {XLEN{1'b0}};
    end else begin
      tag_r   <= tag_nxt_s;
      ready_r <= ready_nxt;
      value_r <= value_nxt_s;
    end
  end

  assign ready = ready_r;
  assign value = value_r;

endmodule

// File: rtl/rs_br_slot.sv
// rs_br_slot: single reservation-station slot for the branch/jump unit.
// Holds one dispatched branch, wakes its operands from the CDB, issues a
// one-cycle fu_selected pulse, captures the FU outcome and holds it on the
// cmp_* port until cmp_ready.
// Ports: clock/reset (async active-low), squash, disp_* (dispatch),
//   cdb_* (broadcast lanes, lane 0 in LSBs), busy, fu_* (issue side and FU
//   result), cmp_* (completion request / grant). All outputs are registered.
module rs_br_slot
  import rs_br_slot_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic                     disp_valid,
  input  logic [XLEN-1:0]          disp_pc,
  input  logic [XLEN-1:0]          disp_npc,
  input  logic [31:0]              disp_inst,
  input  logic                     disp_cond_branch,
  input  logic                     disp_uncond_branch,
  input  logic                     disp_opa_is_rs1,
  input  logic [TAG_W-1:0]         disp_rob_tag,
  input  logic [TAG_W-1:0]         disp_t1,
  input  logic [TAG_W-1:0]         disp_t2,
  input  logic                     disp_r1,
  input  logic                     disp_r2,
  input  logic [XLEN-1:0]          disp_v1,
  input  logic [XLEN-1:0]          disp_v2,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
  output logic                     busy,
  output logic                     fu_selected,
  output logic [XLEN-1:0]          fu_rs1,
  output logic [XLEN-1:0]          fu_rs2,
  output logic                     fu_value_valid,
  output logic [XLEN-1:0]          fu_pc,
  output logic [XLEN-1:0]          fu_npc,
  output logic [31:0]              fu_inst,
  input  logic                     fu_result_valid,
  input  logic                     fu_take_branch,
  input  logic [XLEN-1:0]          fu_target,
  output logic                     cmp_valid,
  output logic [TAG_W-1:0]         cmp_tag,
  output logic                     cmp_take_branch,
  output logic [XLEN-1:0]          cmp_target,
  output logic [XLEN-1:0]          cmp_link,
  input  logic                     cmp_ready
);

  slot_state_e      state_r, state_nxt_s;
  cdb_lane_t        cdb_lanes_s [NUM_CDB];
  logic             accept_s, clear_s, ops_ready_s;
  logic             r1_eff_s, r2_eff_s;
  logic             rdy1_nxt_s, rdy2_nxt_s, rdy1_s, rdy2_s;
  logic             busy_r, fu_selected_r, fu_value_valid_r;
  logic [XLEN-1:0]  pc_r, npc_r;
  logic [31:0]      inst_r;
  logic [TAG_W-1:0] rob_tag_r;
  logic             cmp_valid_r, cmp_take_r;
  logic [TAG_W-1:0] cmp_tag_r;
  logic [XLEN-1:0]  cmp_target_r, cmp_link_r;

  // Split the flat CDB buses into per-lane records.
  always_comb begin
    for (int i = 0; i < NUM_CDB; i++) begin
      cdb_lanes_s[i].valid = cdb_valid[i];
      cdb_lanes_s[i].tag   = cdb_tag[i*TAG_W +: TAG_W];
      cdb_lanes_s[i].value = cdb_value[i*XLEN +: XLEN];
    end
  end

  // Operands an instruction never reads (rs1 when the base is the PC, rs2 on
  // JAL/JALR) must not hold the slot back, so they enter as already ready.
  assign r1_eff_s    = disp_r1 | ~disp_opa_is_rs1;
  assign r2_eff_s    = disp_r2 | ~disp_cond_branch | disp_uncond_branch;
  assign accept_s    = (state_r == SLOT_EMPTY) && disp_valid;
  assign clear_s     = squash || ((state_r == SLOT_DONE) && cmp_ready);
  assign ops_ready_s = rdy1_nxt_s && rdy2_nxt_s;

  rs_operand_snoop u_op1 (
    .clock(clock), .reset(reset), .clear(clear_s), .load(accept_s),
    .snoop(state_r == SLOT_WAIT_OPS), .disp_tag(disp_t1), .disp_ready(r1_eff_s),
    .disp_value(disp_v1), .cdb(cdb_lanes_s), .ready_nxt(rdy1_nxt_s),
    .ready(rdy1_s), .value(fu_rs1)
  );

  rs_operand_snoop u_op2 (
    .clock(clock), .reset(reset), .clear(clear_s), .load(accept_s),
    .snoop(state_r == SLOT_WAIT_OPS), .disp_tag(disp_t2), .disp_ready(r2_eff_s),
    .disp_value(disp_v2), .cdb(cdb_lanes_s), .ready_nxt(rdy2_nxt_s),
    .ready(rdy2_s), .value(fu_rs2)
  );

  // Slot FSM next state; squash overrides everything. A dispatch whose operands
  // are already (or forwarded) ready goes straight to ISSUE.
  always_comb begin
    state_nxt_s = state_r;
    if (squash) begin
      state_nxt_s = SLOT_EMPTY;
    end else begin
      case (state_r)
        SLOT_EMPTY:    state_nxt_s = disp_valid ? (ops_ready_s ? SLOT_ISSUE : SLOT_WAIT_OPS)
                                                : SLOT_EMPTY;
        SLOT_WAIT_OPS: state_nxt_s = ops_ready_s ? SLOT_ISSUE : SLOT_WAIT_OPS;
        SLOT_ISSUE:    state_nxt_s = SLOT_EXEC;
        SLOT_EXEC:     state_nxt_s = fu_result_valid ? SLOT_DONE : SLOT_EXEC;
        SLOT_DONE:     state_nxt_s = cmp_ready ? SLOT_EMPTY : SLOT_DONE;
        default:       state_nxt_s = SLOT_EMPTY;
      endcase
    end
  end

  // State register plus status flags decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r          <= SLOT_EMPTY;
      busy_r           <= 1'b0;
      fu_selected_r    <= 1'b0;
      fu_value_valid_r <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      busy_r           <= (state_nxt_s != SLOT_EMPTY);
      fu_selected_r    <= (state_nxt_s == SLOT_ISSUE);
      fu_value_valid_r <= (state_nxt_s == SLOT_ISSUE) || (state_nxt_s == SLOT_EXEC);
    end
  end

  // Instruction fields captured on dispatch; zeroed when the slot empties.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r      <= {XLEN{1'b0}};
      npc_r     <= {XLEN{1'b0}};
      inst_r    <= 32'd0;
      rob_tag_r <= {TAG_W{1'b0}};
    end else if (clear_s) begin
      pc_r      <= {XLEN{1'b0}};
      npc_r     <= {XLEN{1'b0}};
      inst_r    <= 32'd0;
      rob_tag_r <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      pc_r      <= disp_pc;
      npc_r     <= disp_npc;
      inst_r    <= disp_inst;
      rob_tag_r <= disp_rob_tag;
    end else begin
      pc_r      <= pc_r;
      npc_r     <= npc_r;
      inst_r    <= inst_r;
      rob_tag_r <= rob_tag_r;
    end
  end

  // Completion record: loaded from the FU only in EXEC, held until granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmp_valid_r  <= 1'b0;
      cmp_take_r   <= 1'b0;
      cmp_tag_r    <= {TAG_W{1'b0}};
      cmp_target_r <= {XLEN{1'b0}};
      cmp_link_r   <= {XLEN{1'b0}};
    end else if (clear_s) begin
      cmp_valid_r  <= 1'b0;
      cmp_take_r   <= 1'b0;
      cmp_tag_r    <= {TAG_W{1'b0}};
      cmp_target_r <= {XLEN{1'b0}};
      cmp_link_r   <= {XLEN{1'b0}};
    end else if ((state_r == SLOT_EXEC) && fu_result_valid) begin
      cmp_valid_r  <= 1'b1;
      cmp_take_r   <= fu_take_branch;
      cmp_tag_r    <= rob_tag_r;
      cmp_target_r <= fu_target;
      cmp_link_r   <= npc_r;
    end else begin
      cmp_valid_r  <= cmp_valid_r;
      cmp_take_r   <= cmp_take_r;
      cmp_tag_r    <= cmp_tag_r;
      cmp_target_r <= cmp_target_r;
      cmp_link_r   <= cmp_link_r;
    end
  end

  assign busy            = busy_r;
  assign fu_selected     = fu_selected_r;
  assign fu_value_valid  = fu_value_valid_r;
  assign fu_pc           = pc_r;
  assign fu_npc          = npc_r;
  assign fu_inst         = inst_r;
  assign cmp_valid       = cmp_valid_r;
  assign cmp_tag         = cmp_tag_r;
  assign cmp_take_branch = cmp_take_r;
  assign cmp_target      = cmp_target_r;
  assign cmp_link        = cmp_link_r;

  // Operand ready flags feed only the FSM through ready_nxt; the registered
  // copies are kept visible for debug and folded here to keep them live.
  logic ops_ready_r_s;
  assign ops_ready_r_s = rdy1_s & rdy2_s;
  logic unused_s;
  assign unused_s = ops_ready_r_s;

endmodule

// File: tb/tb_rs_br_slot.sv
// tb_rs_br_slot: directed scoreboard bench for rs_br_slot. Stimulus pushes the
// expected issue and completion records; a negedge monitor pops and compares.
module tb_rs_br_slot;
  import rs_br_slot_pkg::*;

  typedef struct packed {
    logic [31:0] rs1, rs2, pc, npc, inst;
  } issue_t;

  typedef struct packed {
    logic [4:0]  tag;
    logic        take;
    logic [31:0] target, link;
  } cmp_t;

  logic clock = 1'b0, reset = 1'b0, squash = 1'b0;
  logic disp_valid = 1'b0, disp_cond_branch = 1'b0, disp_uncond_branch = 1'b0, disp_opa_is_rs1 = 1'b0;
  logic [31:0] disp_pc = 32'd0, disp_npc = 32'd0, disp_inst = 32'd0, disp_v1 = 32'd0, disp_v2 = 32'd0;
  logic [4:0] disp_rob_tag = 5'd0, disp_t1 = 5'd0, disp_t2 = 5'd0;
  logic disp_r1 = 1'b0, disp_r2 = 1'b0;
  logic [1:0] cdb_valid = 2'd0;
  logic [9:0] cdb_tag = 10'd0;
  logic [63:0] cdb_value = 64'd0;
  logic busy, fu_selected, fu_value_valid, cmp_valid, cmp_take_branch;
  logic [31:0] fu_rs1, fu_rs2, fu_pc, fu_npc, fu_inst, cmp_target, cmp_link;
  logic [4:0] cmp_tag;
  logic fu_result_valid = 1'b0, fu_take_branch = 1'b0, cmp_ready = 1'b0;
  logic [31:0] fu_target = 32'd0;

  int checks = 0;
  int errors = 0;
  issue_t exp_issue_q[$];
  cmp_t   exp_cmp_q[$];

  rs_br_slot dut (
    .clock(clock), .reset(reset), .squash(squash), .disp_valid(disp_valid),
    .disp_pc(disp_pc), .disp_npc(disp_npc), .disp_inst(disp_inst),
    .disp_cond_branch(disp_cond_branch), .disp_uncond_branch(disp_uncond_branch),
    .disp_opa_is_rs1(disp_opa_is_rs1), .disp_rob_tag(disp_rob_tag),
    .disp_t1(disp_t1), .disp_t2(disp_t2), .disp_r1(disp_r1), .disp_r2(disp_r2),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .busy(busy), .fu_selected(fu_selected), .fu_rs1(fu_rs1),
    .fu_rs2(fu_rs2), .fu_value_valid(fu_value_valid), .fu_pc(fu_pc), .fu_npc(fu_npc),
    .fu_inst(fu_inst), .fu_result_valid(fu_result_valid), .fu_take_branch(fu_take_branch),
    .fu_target(fu_target), .cmp_valid(cmp_valid), .cmp_tag(cmp_tag),
    .cmp_take_branch(cmp_take_branch), .cmp_target(cmp_target), .cmp_link(cmp_link),
    .cmp_ready(cmp_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every issue pulse and every completion cycle against the queues.
  always @(negedge clock) begin
    if (reset) begin
      if (fu_selected) begin
        if (exp_issue_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected actual=pulse required=none pc=%h", fu_pc);
        end else begin
          chk("issue_fields", {fu_value_valid, fu_rs1, fu_rs2, fu_pc, fu_npc, fu_inst},
              {1'b1, exp_issue_q.pop_front()});
        end
      end
      if (cmp_valid) begin
        if (exp_cmp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmp_unexpected actual=valid required=none tag=%h", cmp_tag);
        end else begin
          chk("cmp_fields", {cmp_tag, cmp_take_branch, cmp_target, cmp_link}, exp_cmp_q[0]);
          if (cmp_ready) void'(exp_cmp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_disp(input logic [31:0] pc, input logic [4:0] tag, input logic [4:0] t1,
                            input logic [4:0] t2, input logic r1, input logic r2,
                            input logic [31:0] v1, input logic [31:0] v2);
    disp_valid = 1'b1; disp_pc = pc; disp_npc = pc + 32'd4; disp_inst = 32'h00B50463 ^ pc;
    disp_cond_branch = 1'b1; disp_uncond_branch = 1'b0; disp_opa_is_rs1 = 1'b1;
    disp_rob_tag = tag; disp_t1 = t1; disp_t2 = t2; disp_r1 = r1; disp_r2 = r2;
    disp_v1 = v1; disp_v2 = v2;
  endtask

  task automatic set_cdb(input int lane, input logic v, input logic [4:0] tag, input logic [31:0] val);
    cdb_valid[lane] = v;
    cdb_tag[lane*5 +: 5] = tag;
    cdb_value[lane*32 +: 32] = val;
  endtask

  // Called during the ISSUE cycle: a bogus result in ISSUE must be ignored, the
  // real one arrives in EXEC, then completion is held for 'hold' cycles.
  task automatic finish_op(input logic [4:0] tag, input logic take, input logic [31:0] target,
                           input logic [31:0] link, input int hold);
    fu_result_valid = 1'b1; fu_take_branch = ~take; fu_target = ~target;
    tick();
    chk("exec_flags", {fu_selected, fu_value_valid, busy}, 3'b011);
    fu_take_branch = take; fu_target = target;
    exp_cmp_q.push_back('{tag, take, target, link});
    tick();
    fu_result_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("done_busy", {busy, cmp_valid}, 2'b11);
      tick();
    end
    cmp_ready = 1'b1; disp_valid = 1'b0;
    tick();
    cmp_ready = 1'b0;
    chk("after_grant", {busy, cmp_valid, fu_value_valid, fu_rs1, fu_pc}, 67'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("reset_state", {busy, fu_selected, fu_value_valid, cmp_valid, fu_rs1, fu_pc, cmp_target}, 100'd0);
    tick();
    reset = 1'b1;
    tick();

    // Ready dispatch: BEQ at 0x100, both operands 5, issue next cycle.
    drive_disp(32'h100, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 32'd5, 32'd5);
    exp_issue_q.push_back('{32'd5, 32'd5, 32'h100, 32'h104, 32'h00B50463 ^ 32'h100});
    tick();
    disp_valid = 1'b0;
    chk("ready_issue_latency", {fu_selected, busy}, 2'b11);
    finish_op(5'd1, 1'b1, 32'h108, 32'h104, 0);

    // CDB wakeup on lane 1, with a blocked second dispatch and a wrong-tag lane 0.
    drive_disp(32'h200, 5'd2, 5'd3, 5'd0, 1'b0, 1'b1, 32'd0, 32'd7);
    exp_issue_q.push_back('{32'd7, 32'd7, 32'h200, 32'h204, 32'h00B50463 ^ 32'h200});
    tick();
    chk("wait_ops", {busy, fu_selected, fu_value_valid}, 3'b100);
    drive_disp(32'hBAD0, 5'd9, 5'd3, 5'd0, 1'b1, 1'b1, 32'hEEEE, 32'hEEEE);
    set_cdb(0, 1'b1, 5'd2, 32'h88);
    tick();
    disp_valid = 1'b0;
    chk("no_false_wake", {busy, fu_selected}, 2'b10);
    set_cdb(0, 1'b0, 5'd3, 32'h99);
    set_cdb(1, 1'b1, 5'd3, 32'd7);
    tick();
    set_cdb(0, 1'b0, 5'd0, 32'd0); set_cdb(1, 1'b0, 5'd0, 32'd0);
    chk("wake_issue", fu_selected, 1'b1);
    finish_op(5'd2, 1'b0, 32'h300, 32'h204, 0);

    // Dual wake from two lanes in one cycle; completion back-pressured 4 cycles
    // while another dispatch is presented.
    drive_disp(32'h300, 5'd3, 5'd4, 5'd9, 1'b0, 1'b0, 32'd0, 32'd0);
    exp_issue_q.push_back('{32'h10, 32'h20, 32'h300, 32'h304, 32'h00B50463 ^ 32'h300});
    tick();
    disp_valid = 1'b0;
    tick();
    set_cdb(0, 1'b1, 5'd9, 32'h20); set_cdb(1, 1'b1, 5'd4, 32'h10);
    tick();
    set_cdb(0, 1'b0, 5'd0, 32'd0); set_cdb(1, 1'b0, 5'd0, 32'd0);
    chk("dual_wake_issue", fu_selected, 1'b1);
    drive_disp(32'hBAD4, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF);
    finish_op(5'd3, 1'b1, 32'h3F0, 32'h304, 4);

    // Same-cycle forward at dispatch; lane 0 wins over lane 1; ready rs2 ignores CDB.
    drive_disp(32'h400, 5'd4, 5'd6, 5'd6, 1'b0, 1'b1, 32'd0, 32'h77);
    set_cdb(0, 1'b1, 5'd6, 32'h55); set_cdb(1, 1'b1, 5'd6, 32'h66);
    exp_issue_q.push_back('{32'h55, 32'h77, 32'h400, 32'h404, 32'h00B50463 ^ 32'h400});
    tick();
    disp_valid = 1'b0;
    set_cdb(0, 1'b0, 5'd0, 32'd0); set_cdb(1, 1'b0, 5'd0, 32'd0);
    chk("forward_issue", fu_selected, 1'b1);
    finish_op(5'd4, 1'b0, 32'h500, 32'h404, 1);

    // Squash in EXEC together with fu_result_valid: no completion may follow.
    drive_disp(32'h500, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 32'd1, 32'd2);
    exp_issue_q.push_back('{32'd1, 32'd2, 32'h500, 32'h504, 32'h00B50463 ^ 32'h500});
    tick();
    disp_valid = 1'b0;
    chk("squash_pre_issue", fu_selected, 1'b1);
    tick();
    squash = 1'b1; fu_result_valid = 1'b1; fu_take_branch = 1'b1; fu_target = 32'h777;
    tick();
    squash = 1'b0; fu_result_valid = 1'b0;
    chk("squash_empty", {busy, cmp_valid, fu_selected, fu_value_valid, fu_rs1}, 36'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("squash_no_cmp", {busy, cmp_valid}, 2'b00);

    // Async reset while the slot is in DONE.
    drive_disp(32'h600, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 32'd3, 32'd4);
    exp_issue_q.push_back('{32'd3, 32'd4, 32'h600, 32'h604, 32'h00B50463 ^ 32'h600});
    tick();
    disp_valid = 1'b0;
    tick();
    fu_result_valid = 1'b1; fu_take_branch = 1'b1; fu_target = 32'h640;
    tick();
    fu_result_valid = 1'b0;
    chk("pre_reset_done", {cmp_valid, cmp_target, cmp_link}, {1'b1, 32'h640, 32'h604});
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_ctrl", {busy, fu_selected, fu_value_valid, cmp_valid, cmp_take_branch, cmp_tag}, 10'd0);
    chk("async_reset_data", {fu_rs1, fu_rs2, fu_pc, fu_npc, fu_inst}, 160'd0);
    chk("async_reset_cmp", {cmp_target, cmp_link}, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_idle", {busy, cmp_valid}, 2'b00);

    chk("issue_q_drained", exp_issue_q.size(), 160'd0);
    chk("cmp_q_drained", exp_cmp_q.size(), 160'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
